// File: rtl/l0_ctrl_if.sv
// Control-pin bundle between the core sequencer, the L0 controller, the activation SRAM and L0.
// The slave side is the controller; the master side is the sequencer or L0/SRAM model.
interface l0_ctrl_if #(
  parameter int row    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 7
);
  logic              start;
  logic              mode;
  logic [addr_w-1:0] base_addr;
  logic [len_w-1:0]  len;
  logic              l0_full;
  logic              mem_cen;
  logic [addr_w-1:0] mem_addr;
  logic              l0_wr;
  logic [row-1:0]    l0_rd;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, mode, base_addr, len, l0_full,
    input  mem_cen, mem_addr, l0_wr, l0_rd, busy, done, err
  );

  modport slave (
    input  start, mode, base_addr, len, l0_full,
    output mem_cen, mem_addr, l0_wr, l0_rd, busy, done, err
  );
endinterface

// File: rtl/l0_ctrl.sv
// L0 input-buffer sequencer: streams len vectors SRAM -> L0, then drains L0 into the
// MAC array either in lockstep (mode 0) or as a one-row-per-cycle diagonal wavefront (mode 1).
module l0_ctrl #(
  parameter int row    = 8,
  parameter int addr_w = 11,
  parameter int depth  = 64,
  parameter int len_w  = 7
) (
  input  logic        clk,
  input  logic        reset,
  l0_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    idle_st  = 2'd0,
    load_st  = 2'd1,
    drain_st = 2'd2,
    done_st  = 2'd3
  } state_t;

  localparam logic [len_w-1:0] depth_c    = len_w'(depth);
  localparam logic [len_w-1:0] one_c      = len_w'(1);
  localparam logic [row-1:0]   first_diag = {{(row-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic              mode_r;
  logic [addr_w-1:0] base_r;
  logic [len_w-1:0]  len_r;
  logic [len_w-1:0]  iss_cnt_r;
  logic [len_w-1:0]  wr_cnt_r;
  logic [len_w-1:0]  rd_cnt_r;
  logic              mem_cen_r;
  logic [addr_w-1:0] mem_addr_r;
  logic              l0_wr_r;
  logic [row-1:0]    l0_rd_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              rd_issue_s;
  logic [row-1:0]    rd_next_s;

  // Next drain issue bit and the read-enable vector it produces one cycle ahead
  always_comb begin
    rd_issue_s = 1'b0;
    rd_next_s  = '0;
    if (state_r == drain_st) begin
      rd_issue_s = (rd_cnt_r < len_r);
      if (mode_r) begin
        rd_next_s = {l0_rd_r[row-2:0], rd_issue_s};
      end else begin
        rd_next_s = {row{rd_issue_s}};
      end
    end else begin
      rd_issue_s = 1'b0;
      rd_next_s  = '0;
    end
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= idle_st;
      mode_r     <= 1'b0;
      base_r     <= '0;
      len_r      <= '0;
      iss_cnt_r  <= '0;
      wr_cnt_r   <= '0;
      rd_cnt_r   <= '0;
      mem_cen_r  <= 1'b1;
      mem_addr_r <= '0;
      l0_wr_r    <= 1'b0;
      l0_rd_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      // SRAM data lands one cycle after the strobe, so the L0 write trails it
      l0_wr_r <= ~mem_cen_r;
      case (state_r)
        idle_st: begin
          done_r <= 1'b0;
          if (bus.start) begin
            mode_r <= bus.mode;
            base_r <= bus.base_addr;
            len_r  <= bus.len;
            err_r  <= 1'b0;
            if (bus.len == '0) begin
              done_r  <= 1'b1;
              state_r <= done_st;
            end else if (bus.len > depth_c) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= done_st;
            end else begin
              state_r    <= load_st;
              busy_r     <= 1'b1;
              mem_cen_r  <= 1'b0;
              mem_addr_r <= bus.base_addr;
              iss_cnt_r  <= one_c;
              wr_cnt_r   <= '0;
              rd_cnt_r   <= '0;
            end
          end
        end
        load_st: begin
          // A full L0 suppresses the next issue; the address register simply holds
          if ((iss_cnt_r < len_r) && !bus.l0_full) begin
            mem_cen_r  <= 1'b0;
            mem_addr_r <= base_r + addr_w'(iss_cnt_r);
            iss_cnt_r  <= iss_cnt_r + one_c;
          end else begin
            mem_cen_r <= 1'b1;
          end
          if (l0_wr_r) begin
            if (wr_cnt_r == (len_r - one_c)) begin
              state_r  <= drain_st;
              rd_cnt_r <= one_c;
              l0_rd_r  <= mode_r ? first_diag : {row{1'b1}};
            end else begin
              wr_cnt_r <= wr_cnt_r + one_c;
            end
          end
        end
        drain_st: begin
          l0_rd_r <= rd_next_s;
          if (rd_issue_s) begin
            rd_cnt_r <= rd_cnt_r + one_c;
          end else if (rd_next_s == '0) begin
            state_r <= done_st;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        done_st: begin
          done_r  <= 1'b0;
          state_r <= idle_st;
        end
        default: begin
          state_r <= idle_st;
        end
      endcase
    end
  end

  assign bus.mem_cen  = mem_cen_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.l0_wr    = l0_wr_r;
  assign bus.l0_rd    = l0_rd_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_l0_ctrl.sv
// Directed bench for l0_ctrl: a table of transfer scenarios with hand-computed completion
// cycles, expanded cycle by cycle from the documented timing, plus a mid-run reset sequence.
module tb_l0_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  l0_ctrl_if #(.row(8), .addr_w(11), .len_w(7)) bus ();

  l0_ctrl #(.row(8), .addr_w(11), .depth(64), .len_w(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [10:0] base;
    logic [6:0]  len;
    int          stall;     // cycle with l0_full=1, -1 for none
    int          restart;   // cycle with a stray start pulse, 0 for none
    int          exp_done;  // cycle in which done is expected
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit          iss [0:299];
    logic [10:0] adr [0:299];
    logic [10:0] cur;
    logic [7:0]  e_rd;
    int          k;
    int          last_iss;
    int          d;
    int          lo;
    bit          load_path;
    load_path = (v.len != 7'd0) && (v.len <= 7'd64);
    k = 0;
    last_iss = 0;
    cur = 11'h000;
    for (int c = 0; c < 300; c++) begin
      iss[c] = 1'b0;
      adr[c] = 11'h000;
    end
    if (load_path) begin
      for (int c = 1; c < 300 && k < int'(v.len); c++) begin
        if (v.stall >= 1 && c == v.stall + 1) begin
          adr[c] = cur;
        end else begin
          iss[c] = 1'b1;
          cur = v.base + 11'(k);
          adr[c] = cur;
          k++;
          last_iss = c;
        end
      end
    end
    d = last_iss + 2;

    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.mode      = v.mode;
    bus.base_addr = v.base;
    bus.len       = v.len;
    bus.l0_full   = 1'b0;

    for (int c = 1; c <= v.exp_done + 2; c++) begin
      @(posedge clk); #1;
      e_rd = 8'h00;
      for (int i = 0; i < 8; i++) begin
        lo = d + (v.mode ? i : 0);
        e_rd[i] = load_path && (c >= lo) && (c < lo + int'(v.len));
      end
      chk("mem_cen", c, int'(bus.mem_cen), int'(!iss[c]));
      chk("l0_wr",   c, int'(bus.l0_wr),   int'(iss[c-1]));
      chk("l0_rd",   c, int'(bus.l0_rd),   int'(e_rd));
      chk("busy",    c, int'(bus.busy),    int'(load_path && c < v.exp_done));
      chk("done",    c, int'(bus.done),    int'(c == v.exp_done));
      chk("err",     c, int'(bus.err),     int'(v.exp_err));
      if (load_path && c <= last_iss) begin
        chk("mem_addr", c, int'(bus.mem_addr), int'(adr[c]));
      end
      if (c == v.restart) begin
        bus.start     = 1'b1;
        bus.mode      = ~v.mode;
        bus.base_addr = 11'h555;
        bus.len       = 7'd9;
      end else begin
        bus.start = 1'b0;
      end
      bus.l0_full = (c == v.stall);
    end
  endtask

  task automatic chk_reset_vals(input int cyc);
    chk("rst_mem_cen",  cyc, int'(bus.mem_cen),  1);
    chk("rst_mem_addr", cyc, int'(bus.mem_addr), 0);
    chk("rst_l0_wr",    cyc, int'(bus.l0_wr),    0);
    chk("rst_l0_rd",    cyc, int'(bus.l0_rd),    0);
    chk("rst_busy",     cyc, int'(bus.busy),     0);
    chk("rst_done",     cyc, int'(bus.done),     0);
    chk("rst_err",      cyc, int'(bus.err),      0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //           mode  base     len    stall restart done err
    vecs[0] = '{1'b0, 11'h010, 7'd4,  -1,   0,      10,  1'b0};
    vecs[1] = '{1'b1, 11'h010, 7'd4,  -1,   0,      17,  1'b0};
    vecs[2] = '{1'b0, 11'h010, 7'd4,   2,   0,      11,  1'b0};
    vecs[3] = '{1'b0, 11'h010, 7'd0,  -1,   0,       1,  1'b0};
    vecs[4] = '{1'b1, 11'h010, 7'd65, -1,   0,       1,  1'b1};
    vecs[5] = '{1'b0, 11'h010, 7'd4,  -1,   2,      10,  1'b0};
    vecs[6] = '{1'b1, 11'h7F0, 7'd64, -1,   0,     137,  1'b0};
    vecs[7] = '{1'b0, 11'h7FF, 7'd1,  -1,   0,       4,  1'b0};
    vecs[8] = '{1'b1, 11'h010, 7'd4,   2,   0,      18,  1'b0};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.base_addr = 11'h000;
    bus.len       = 7'd0;
    bus.l0_full   = 1'b0;
    #2;
    chk_reset_vals(0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals(0);

    for (int n = 0; n < 9; n++) begin
      run_vec(vecs[n]);
    end

    // Asynchronous reset in cycle 7 of a mode 1, len 8 run
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.mode      = 1'b1;
    bus.base_addr = 11'h020;
    bus.len       = 7'd8;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("pre_rst_busy",    7, int'(bus.busy),     1);
    chk("pre_rst_mem_cen", 7, int'(bus.mem_cen),  0);
    chk("pre_rst_addr",    7, int'(bus.mem_addr), 'h026);
    chk("pre_rst_l0_wr",   7, int'(bus.l0_wr),    1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals(7);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_vals(8);
    run_vec('{1'b1, 11'h020, 7'd8, -1, 0, 25, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l0_ctrl.md
# l0_ctrl

Sequencing controller for the L0 input buffer (row-parallel FIFO bank, depth 64 per row) feeding the MAC array. On `start` it streams `len` input vectors from activation SRAM into L0, then drains L0 into the array, either all rows in lockstep or as a one-cycle-per-row diagonal wavefront. It sits between the core's top-level sequencer and the L0/SRAM pair, and drives only their control pins; data flows SRAM → L0 directly.

## Interface
- `row`, 8, number of L0 rows; width of `l0_rd`
- `addr_w`, 11, SRAM address width
- `depth`, 64, L0 FIFO depth per row; maximum legal `len`
- `len_w`, 7, width of `len`; must hold `depth`

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle request, sampled in IDLE only
- `mode` in 1: 0 = all rows read together, 1 = staggered rows
- `base_addr` in `addr_w`: first SRAM address
- `len` in `len_w`: number of vectors to move
- `l0_full` in 1: L0 full, any row
- `mem_cen` out 1: SRAM chip enable, active-low read strobe
- `mem_addr` out `addr_w`: SRAM read address
- `l0_wr` out 1: L0 write strobe
- `l0_rd` out `row`: per-row L0 read enables
- `busy` out 1: high in LOAD and DRAIN
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky config-error flag

## Operation
- All outputs registered. Reset values: `mem_cen`=1, `mem_addr`=0, `l0_wr`=0, `l0_rd`=0, `busy`=0, `done`=0, `err`=0; state IDLE; counters 0.
- IDLE: on `start`, latch `mode`, `base_addr`, `len`, and clear `err`.
  - `len`=0 goes to DONE.
  - `len`>`depth` sets `err` and goes to DONE.
  - Otherwise goes to LOAD.
  - `start` outside IDLE is ignored.
- LOAD: issues one read per cycle (`mem_cen`=0, `mem_addr`=base+k, k=0..len-1) while `l0_full`=0.
  - If `l0_full`=1 in cycle t, cycle t+1 has no issue: `mem_cen`=1, `mem_addr` holds.
  - SRAM data is valid one cycle after `mem_cen`=0, so `l0_wr` is `mem_cen` inverted and delayed one cycle.
  - Leave LOAD when `len` writes are complete.
  - `mem_addr` wraps modulo 2^`addr_w`.
- DRAIN: an internal issue bit is high for exactly `len` consecutive cycles.
  - mode 0: every bit of `l0_rd` equals the issue bit.
  - mode 1: `l0_rd` = {`l0_rd`[row-2:0], issue}, so row i is delayed by i cycles.
  - Leave DRAIN when all `len` issues are done and `l0_rd`==0.
- DONE: one cycle with `done`=1, then IDLE.
- `err` stays set until the next accepted `start`.

## Timing
- `start` is high in cycle 0. For an unstalled transfer of length L:
  - reads issue in cycles 1..L;
  - `l0_wr` is high in cycles 2..L+1;
  - DRAIN starts in cycle L+2.
- mode 0:
  - `l0_rd`=all-ones in cycles L+2..2L+1;
  - `done` is high in cycle 2L+2.
- mode 1:
  - `l0_rd`[i] is high in cycles L+2+i..2L+1+i;
  - `done` is high in cycle 2L+row+1.
- Each `l0_full` stall cycle delays the remaining schedule by one cycle.
- Error and `len`=0 path: `done` (with `err` where it applies) in cycle 1; `busy` never rises.
- `busy` is high from the first LOAD cycle through the last DRAIN cycle and low in DONE.
- Reset asserted mid-operation forces reset values immediately. In-flight SRAM data is not written to L0; the L0 contents are reset separately.

## Test plan
- Reset with `start`=0: all outputs at reset values. Then mode 0, base 0x10, len 4:
  - `mem_addr` 0x10..0x13 with `mem_cen`=0 in cycles 1–4;
  - `l0_wr` high in cycles 2–5;
  - `l0_rd`=8'hFF in cycles 6–9;
  - `done` high in cycle 10.
- mode 1, len 4:
  - `l0_rd`[0] high in cycles 6–9;
  - `l0_rd`[7] high in cycles 13–16;
  - `l0_rd` shows the diagonal pattern in between;
  - `done` high in cycle 17.
- len 4 with `l0_full`=1 during cycle 2 only:
  - no read in cycle 3; `mem_addr` holds at 0x11;
  - addresses 0x12 and 0x13 issue in cycles 4 and 5;
  - `done` arrives exactly one cycle later than the unstalled case.
- len 0: `done`=1 and `err`=0 in cycle 1. len 65: `done`=1 and `err`=1 in cycle 1, and `err` stays high until the next `start`.
- `start` pulse during LOAD: ignored; latched parameters unchanged; the schedule is identical to the single-start run.
- `reset` asserted in cycle 7 of a mode 1, len 8 run: outputs return to reset values without waiting for a clock edge; a new `start` then completes normally.
